// File: rtl/updown_step_decoder_pkg.sv
// Shared types and step classification for the up/down step counter link.
package updown_step_decoder_pkg;

  localparam logic [0:0] ST_UNLOCKED_ENC = 1'b0;
  localparam logic [0:0] ST_LOCKED_ENC   = 1'b1;

  typedef enum logic [0:0] {
    UNLOCKED = ST_UNLOCKED_ENC,
    LOCKED   = ST_LOCKED_ENC
  } state_t;

  typedef enum logic [1:0] {
    STEP_UP  = 2'd0,
    STEP_DN  = 2'd1,
    STEP_BAD = 2'd2
  } step_t;

  // Classify (cur - prev) mod 2^width as +1, -1 or anything else.
  function automatic step_t classify_step(input logic [31:0] prev,
                                          input logic [31:0] cur,
                                          input int unsigned width);
    logic [31:0] mask;
    logic [31:0] delta;
    mask  = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    delta = (cur - prev) & mask;
    if (delta == 32'd1)
      return STEP_UP;
    else if (delta == mask)
      return STEP_DN;
    else
      return STEP_BAD;
  endfunction

endpackage

// File: rtl/updown_step_decoder_if.sv
// Sample input, packed-word output handshake and status flags of the decoder.
interface updown_step_decoder_if #(
  parameter int WIDTH = 3,
  parameter int PACK  = 8
);
  logic [WIDTH-1:0] cnt_in;
  logic             cnt_vld;
  logic [PACK-1:0]  out_data;
  logic             out_valid;
  logic             out_ready;
  logic             locked;
  logic             err_step;
  logic             err_overrun;

  modport master (
    input  cnt_in, cnt_vld, out_ready,
    output out_data, out_valid, locked, err_step, err_overrun
  );

  modport slave (
    output cnt_in, cnt_vld, out_ready,
    input  out_data, out_valid, locked, err_step, err_overrun
  );
endinterface

// File: rtl/updown_step_outreg.sv
// Single-entry valid/ready output register; a word arriving while the entry
// is still occupied and not being drained is dropped and flagged.
module updown_step_outreg #(
  parameter int PACK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_push,
  input  logic [PACK-1:0] i_data,
  input  logic            i_ready,
  output logic [PACK-1:0] o_data,
  output logic            o_valid,
  output logic            o_overrun
);

  logic [PACK-1:0] r_data;
  logic            r_valid;
  logic            r_overrun;
  logic            w_free;

  // Entry can accept a word when empty or being handed off this cycle.
  always_comb begin
    w_free = !r_valid || i_ready;
  end

  // Load, drain and overrun flag for the output entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (i_push && w_free) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_push && !w_free)
        r_overrun <= 1'b1;
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/updown_step_decoder.sv
// Recovers direction bits from an up/down counter sample stream and packs
// them LSB-first into PACK-bit words.
module updown_step_decoder
  import updown_step_decoder_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int PACK  = 8
) (
  input logic                 clk,
  input logic                 rst,
  updown_step_decoder_if.master bus
);

  localparam int BCW = (PACK > 1) ? $clog2(PACK) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [PACK-1:0]  r_shift;
  logic [BCW-1:0]   r_bcnt;
  logic             r_err_step;

  step_t            w_step;
  logic             w_last;
  logic             w_push;
  logic [PACK-1:0]  w_word;

  // Classify the incoming step and form the word including the new bit.
  always_comb begin
    w_step         = classify_step(32'(r_prev), 32'(bus.cnt_in), WIDTH);
    w_last         = (r_bcnt == BCW'(PACK - 1));
    w_push         = bus.cnt_vld && (r_state == LOCKED) &&
                     (w_step != STEP_BAD) && w_last;
    w_word         = r_shift;
    w_word[r_bcnt] = (w_step == STEP_UP);
  end

  // Lock, reference tracking, bit packing and illegal-step handling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= UNLOCKED;
      r_prev     <= '0;
      r_shift    <= '0;
      r_bcnt     <= '0;
      r_err_step <= 1'b0;
    end else begin
      r_err_step <= 1'b0;
      if (bus.cnt_vld) begin
        r_prev <= bus.cnt_in;
        if (r_state == UNLOCKED) begin
          r_state <= LOCKED;
        end else if (w_step == STEP_BAD) begin
          r_err_step <= 1'b1;
          r_shift    <= '0;
          r_bcnt     <= '0;
        end else if (w_last) begin
          r_shift <= '0;
          r_bcnt  <= '0;
        end else begin
          r_shift <= w_word;
          r_bcnt  <= r_bcnt + BCW'(1);
        end
      end
    end
  end

  updown_step_outreg #(
    .PACK(PACK)
  ) u_outreg (
    .clk      (clk),
    .rst      (rst),
    .i_push   (w_push),
    .i_data   (w_word),
    .i_ready  (bus.out_ready),
    .o_data   (bus.out_data),
    .o_valid  (bus.out_valid),
    .o_overrun(bus.err_overrun)
  );

  assign bus.locked   = (r_state == LOCKED);
  assign bus.err_step = r_err_step;

endmodule

// File: tb/tb_updown_step_decoder.sv
// Self-checking bench for updown_step_decoder (WIDTH=3, PACK=8).
module tb_updown_step_decoder;

  localparam int W = 3;
  localparam int P = 8;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  updown_step_decoder_if #(.WIDTH(W), .PACK(P)) bus ();

  updown_step_decoder #(.WIDTH(W), .PACK(P)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bit queue plus a one-entry output slot.
  bit             m_locked;
  int             m_prev;
  int             m_bits[$];
  bit             m_valid;
  logic [P-1:0]   m_data;
  bit             m_estep;
  bit             m_eovr;

  function automatic logic [P+3:0] exp_vec();
    return {m_valid, m_data, m_locked, m_estep, m_eovr};
  endfunction

  function automatic logic [P+3:0] act_vec();
    return {bus.out_valid, bus.out_data, bus.locked, bus.err_step, bus.err_overrun};
  endfunction

  // Drive one clock of stimulus, then advance the reference model.
  task automatic cycle(input bit r, input bit v, input int c, input bit rdy);
    int d;
    logic [P-1:0] w;
    rst           = r;
    bus.cnt_vld   = v;
    bus.cnt_in    = W'(c);
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    if (r) begin
      m_locked = 0; m_prev = 0; m_bits.delete();
      m_valid = 0; m_data = '0; m_estep = 0; m_eovr = 0;
    end else begin
      m_estep = 0;
      m_eovr  = 0;
      if (m_valid && rdy) m_valid = 0;
      if (v) begin
        if (!m_locked) begin
          m_locked = 1;
        end else begin
          d = (((c - m_prev) % M) + M) % M;
          if (d == 1)          m_bits.push_back(1);
          else if (d == M - 1) m_bits.push_back(0);
          else begin
            m_estep = 1;
            m_bits.delete();
          end
          if (m_bits.size() == P) begin
            w = '0;
            foreach (m_bits[i]) w[i] = m_bits[i][0];
            m_bits.delete();
            if (!m_valid) begin
              m_valid = 1;
              m_data  = w;
            end else begin
              m_eovr = 1;
            end
          end
        end
        m_prev = c;
      end
    end
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0);
    n_cmp++;
    if (act_vec() !== '0) begin
      n_err++;
      $display("FAIL reset_state got %h want 0", act_vec());
    end
    cycle(0, 0, 0, 0);
    n_cmp++;
    if (act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_idle got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_up_word();
    int s[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    cycle(1, 0, 0, 1);
    foreach (s[i]) begin
      cycle(0, 1, s[i], 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL up_word[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 0) begin
        n_cmp++;
        if (bus.locked !== 1'b1 || bus.out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL up_lock locked=%b valid=%b want 1/0", bus.locked, bus.out_valid);
        end
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin
      n_err++;
      $display("FAIL up_word_out valid=%b data=%h want 1/ff", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_down_wrap();
    int s[9] = '{0, 7, 6, 5, 4, 3, 2, 1, 0};
    int nerr_step = 0;
    cycle(1, 0, 0, 1);
    foreach (s[i]) begin
      cycle(0, 1, s[i], 1);
      if (bus.err_step === 1'b1) nerr_step++;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL down_wrap[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || nerr_step != 0) begin
      n_err++;
      $display("FAIL down_word valid=%b data=%h errs=%0d want 1/00/0",
               bus.out_valid, bus.out_data, nerr_step);
    end
  endtask

  task automatic test_lsb_order();
    int s[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    cycle(1, 0, 0, 1);
    foreach (s[i]) begin
      cycle(0, 1, s[i], 1);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL lsb_order[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h55) begin
      n_err++;
      $display("FAIL lsb_word valid=%b data=%h want 1/55", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_illegal_step();
    int s[13] = '{0, 1, 2, 3, 6, 7, 0, 1, 2, 3, 4, 5, 6};
    int nerr_step = 0;
    cycle(1, 0, 0, 1);
    foreach (s[i]) begin
      cycle(0, 1, s[i], 1);
      if (bus.err_step === 1'b1) nerr_step++;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL illegal[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
      if (i == 4) begin
        n_cmp++;
        if (bus.err_step !== 1'b1) begin
          n_err++;
          $display("FAIL illegal_pulse got %b want 1", bus.err_step);
        end
      end
    end
    n_cmp++;
    if (nerr_step != 1 || bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin
      n_err++;
      $display("FAIL illegal_word errs=%0d valid=%b data=%h want 1/1/ff",
               nerr_step, bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_overrun();
    int novr = 0;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      cycle(0, 1, i % M, 0);
      if (bus.err_overrun === 1'b1) novr++;
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL overrun[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
      if (i >= 8) begin
        n_cmp++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hFF) begin
          n_err++;
          $display("FAIL overrun_hold[%0d] valid=%b data=%h want 1/ff",
                   i, bus.out_valid, bus.out_data);
        end
      end
    end
    n_cmp++;
    if (novr != 1) begin
      n_err++;
      $display("FAIL overrun_count got %0d want 1", novr);
    end
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || act_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL overrun_drain got %h want %h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_back_to_back();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, i % M, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, (8 - i) % M, (i == 8));
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h00 || bus.err_overrun !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_replace valid=%b data=%h ovr=%b want 1/00/0",
               bus.out_valid, bus.out_data, bus.err_overrun);
    end
  endtask

  task automatic test_reset_midword();
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) cycle(0, 1, i % M, 0);
    cycle(1, 1, 6, 0);
    n_cmp++;
    if (act_vec() !== '0) begin
      n_err++;
      $display("FAIL midreset_state got %h want 0", act_vec());
    end
    cycle(0, 1, 3, 0);
    n_cmp++;
    if (bus.locked !== 1'b1 || bus.out_valid !== 1'b0 || bus.err_step !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_ref locked=%b valid=%b err=%b want 1/0/0",
               bus.locked, bus.out_valid, bus.err_step);
    end
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 1, (3 + i) % M, 0);
      n_cmp++;
      if (act_vec() !== exp_vec() || bus.out_valid !== (i == 8)) begin
        n_err++;
        $display("FAIL midreset_step[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int sel, c;
    bit r, v, rdy;
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 3) != 0);
      rdy = $urandom_range(0, 1);
      sel = $urandom_range(0, 19);
      if (sel < 9)       c = (m_prev + 1) % M;
      else if (sel < 18) c = (m_prev + M - 1) % M;
      else               c = $urandom_range(0, M - 1);
      cycle(r, v, c, rdy);
      n_cmp++;
      if (act_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d] got %h want %h", i, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bus.cnt_in    = '0;
    bus.cnt_vld   = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_up_word();
    test_down_wrap();
    test_lsb_order();
    test_illegal_step();
    test_overrun();
    test_back_to_back();
    test_reset_midword();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updown_step_decoder.md
# updown_step_decoder

Receive-side decoder for the synchronous up/down step counter. It samples the counter's WIDTH-bit output stream and recovers the direction bit that drove each step: +1 decodes as 1, −1 as 0. It packs the recovered bits LSB-first into PACK-bit words and delivers them on a valid/ready interface. It flags illegal steps and output overruns, and sits downstream of the counter in the same clock domain.

## Interface
- WIDTH, 3: counter width in bits; must be ≥ 2, because +1 and −1 are indistinguishable at WIDTH=1.
- PACK, 8: recovered bits per output word; must be ≥ 1.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- cnt_in  in  WIDTH  counter value sample.
- cnt_vld  in  1  cnt_in is a valid sample this cycle.
- out_data  out  PACK  packed direction word, bit 0 = oldest step.
- out_valid  out  1  out_data holds an undelivered word.
- out_ready  in  1  consumer accepts the word this cycle.
- locked  out  1  a reference sample is held.
- err_step  out  1  one-cycle pulse on an illegal step.
- err_overrun  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- States:
  - UNLOCKED: reset state.
  - LOCKED: reached on the first cnt_vld sample after reset. That sample is stored in prev and decodes no bit.
- Delta computation in LOCKED, on each cnt_vld: delta = (cnt_in − prev) mod 2^WIDTH.
- Decode rules:
  - delta = 1: shift in bit 1.
  - delta = 2^WIDTH−1: shift in bit 0.
  - Any other delta, including 0: illegal step.
- Wrap-around is legal: 7→0 decodes as up and 0→7 as down (WIDTH=3).
- On every cnt_vld in LOCKED, prev ← cnt_in, including after an illegal step.
- Illegal step:
  - err_step pulses.
  - The partial word and bit count are cleared.
  - The state stays LOCKED; the sample becomes the new reference.
- Bit packing: bits go into shift register position bcnt; bcnt counts 0..PACK−1.
- Word completion: on the PACK-th bit, bcnt → 0 and the completed word transfers to out_data if the output stage is free.
  - Free means out_valid=0, or out_valid=1 with out_ready=1 in the same cycle.
- Overrun: if the output stage is not free, the new word is dropped, err_overrun pulses, and out_data/out_valid are unchanged.
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data is held stable.
  - out_valid drops only after a transfer.
- Samples with cnt_vld=0 are ignored; no state changes.
- Reset values: out_data=0, out_valid=0, locked=0, err_step=0, err_overrun=0, prev=0, bcnt=0, shift register=0.
- Reset mid-word or mid-handshake discards everything, including a pending out_data. The next valid sample is a reference only.

## Timing
- All outputs are registered.
- Decode latency: a sample completing a word at edge N gives out_valid=1 with that word after edge N, i.e. visible in cycle N+1.
- err_step and err_overrun are asserted in the cycle after the offending sample, for exactly one cycle.
- locked rises in the cycle after the first post-reset cnt_vld.
- Full throughput: one sample per cycle, and back-to-back words with out_ready held high.
- Simultaneous transfer and completion in the same cycle: the new word replaces the old one with no bubble and no overrun.
- Simultaneous illegal step and word completion cannot occur: an illegal step shifts no bit.

## Structure
- Shared package holds:
  - state enum {UNLOCKED, LOCKED}.
  - a function returning delta class {STEP_UP, STEP_DN, STEP_BAD} from (prev, cur, WIDTH). The counter bench model reuses it.
- One natural sub-module: updown_step_outreg, the single-entry valid/ready output register with overrun detection.
- Everything else is flat in updown_step_decoder.

## Test plan
- Reset, then samples 0,1,2,3,4,5,6,7,0 (WIDTH=3, PACK=8) → locked after the first sample; out_data=8'hFF and out_valid=1 one cycle after the ninth sample.
- Samples 0,7,6,5,4,3,2,1,0 → out_data=8'h00; the 0→7 wrap decodes as down; no err_step.
- Samples 0,1,0,1,0,1,0,1,0 → out_data=8'h55 (LSB-first ordering).
- Samples 0,1,2,3,(3 bits), then 6 (illegal), then 7,0,1,2,3,4,5,6 → one err_step pulse; next word=8'hFF built from the steps after 6.
- out_ready held 0, 17 up-steps (two words) → first word 8'hFF held stable, one err_overrun pulse at the second completion; after out_ready=1 there is one transfer, then out_valid=0.
- Assert rst after 5 decoded bits with out_valid=1 → all outputs 0; the next sample sets locked only, and 8 further steps are needed for a word.
